// File: rtl/ac_ctrl_pkg.sv
// Shared opcode and state encodings plus default widths for the accumulator
// control sequencer.
package ac_ctrl_pkg;

    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned AC_W_DEF  = 16;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_ALU  = 2'b10,
        OP_INC  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ALU_ISSUE,
        ST_ALU_WAIT,
        ST_INC_RUN,
        ST_FIN
    } state_e;

endpackage

// File: rtl/ac_ctrl_cnt.sv
// Loadable down-counter shared by the INC repeat count and the ALU timeout;
// the two uses never overlap in time.
module ac_ctrl_cnt
    import ac_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             is_one
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_one = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ac_ctrl.sv
// Accumulator strobe micro-sequencer: one command at a time, mutually exclusive
// load / ALU write-back / increment strobes. Optional macro: AC_CTRL_SAT_EN.
module ac_ctrl
    import ac_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned ALU_TIMEOUT = 15,
    parameter int unsigned AC_W        = AC_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             alu_start,
    input  logic             alu_done,
    output logic             ac_write_en,
    output logic             ac_alu_to_ac,
    output logic             ac_inc_en,
    input  logic [AC_W-1:0]  ac_value,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             sat
);

    state_e           state_q, state_d;
    logic             cnt_load, cnt_dec, cnt_is_one;
    logic [CNT_W-1:0] cnt_val;

    ac_ctrl_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .is_one   (cnt_is_one)
    );

`ifndef AC_CTRL_SAT_EN
    logic ac_value_unused;
    assign ac_value_unused = ^ac_value;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_val      = '0;
        cnt_dec      = 1'b0;
        alu_start    = 1'b0;
        ac_write_en  = 1'b0;
        ac_alu_to_ac = 1'b0;
        ac_inc_en    = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        sat          = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    unique case (op_e'(cmd_op))
                        OP_NOP:  state_d = ST_FIN;
                        OP_LOAD: state_d = ST_LOAD;
                        OP_ALU:  state_d = ST_ALU_ISSUE;
                        OP_INC: begin
                            if (cmd_count == '0) begin
                                state_d = ST_FIN;
                            end else begin
                                state_d  = ST_INC_RUN;
                                cnt_load = 1'b1;
                                cnt_val  = cmd_count;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD: begin
                ac_write_en = 1'b1;
                done        = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_ALU_ISSUE: begin
                alu_start = 1'b1;
                cnt_load  = 1'b1;
                cnt_val   = CNT_W'(ALU_TIMEOUT);
                state_d   = ST_ALU_WAIT;
            end
            ST_ALU_WAIT: begin
                // A result arriving in the final timeout cycle still wins over err.
                if (alu_done) begin
                    ac_alu_to_ac = 1'b1;
                    done         = 1'b1;
                    state_d      = ST_IDLE;
                end else if (cnt_is_one) begin
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_INC_RUN: begin
`ifdef AC_CTRL_SAT_EN
                if (ac_value == '1) begin
                    sat     = 1'b1;
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else
`endif
                begin
                    ac_inc_en = 1'b1;
                    cnt_dec   = 1'b1;
                    if (cnt_is_one) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FIN: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ac_ctrl.sv
// Directed scoreboard bench for ac_ctrl with a behavioural accumulator and ALU responder.
`timescale 1ns/1ps
module tb_ac_ctrl;
    import ac_ctrl_pkg::*;

    localparam int unsigned CNT_W       = 8;
    localparam int unsigned AC_W        = 16;
    localparam int unsigned ALU_TIMEOUT = 15;

    logic             clock     = 1'b0;
    logic             reset_n   = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             alu_done  = 1'b0;
    logic [1:0]       cmd_op    = '0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             cmd_ready, alu_start, ac_write_en, ac_alu_to_ac, ac_inc_en;
    logic             busy, done, err, sat;
    logic [AC_W-1:0]  ac_value;
    logic [AC_W-1:0]  datain  = '0;
    logic [AC_W-1:0]  alu_out = '0;
    logic [AC_W-1:0]  acc_q   = '0;

    assign ac_value = acc_q;

    always #5 clock = ~clock;

    ac_ctrl #(.CNT_W(CNT_W), .ALU_TIMEOUT(ALU_TIMEOUT), .AC_W(AC_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_count    (cmd_count),
        .alu_start    (alu_start),
        .alu_done     (alu_done),
        .ac_write_en  (ac_write_en),
        .ac_alu_to_ac (ac_alu_to_ac),
        .ac_inc_en    (ac_inc_en),
        .ac_value     (ac_value),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .sat          (sat)
    );

    // Accumulator datapath model and per-cycle event counters.
    int unsigned n_inc = 0, n_wr = 0, n_alu = 0, n_start = 0;
    int unsigned n_done = 0, n_err = 0, n_sat = 0, n_acc = 0, n_overlap = 0;

    always @(posedge clock) begin
        if (ac_write_en)       acc_q <= datain;
        else if (ac_alu_to_ac) acc_q <= alu_out;
        else if (ac_inc_en)    acc_q <= acc_q + 1'b1;
        if (ac_inc_en)    n_inc   <= n_inc + 1;
        if (ac_write_en)  n_wr    <= n_wr + 1;
        if (ac_alu_to_ac) n_alu   <= n_alu + 1;
        if (alu_start)    n_start <= n_start + 1;
        if (done)         n_done  <= n_done + 1;
        if (err)          n_err   <= n_err + 1;
        if (sat)          n_sat   <= n_sat + 1;
        if (cmd_valid && cmd_ready) n_acc <= n_acc + 1;
        if ((ac_write_en && ac_alu_to_ac) || (ac_write_en && ac_inc_en) || (ac_alu_to_ac && ac_inc_en))
            n_overlap <= n_overlap + 1;
    end

    typedef struct {
        string       tag;
        logic [15:0] acc;
        int          inc;
        int          wr;
        int          alu;
        int          start;
        int          done;
        int          err;
        int          sat;
        int          tmo;
    } exp_t;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic [15:0] acc, input int inc, input int wr,
                                input int alu, input int start, input int dn, input int er,
                                input int st, input int tmo);
        exp_t e;
        e.tag = tag; e.acc = acc; e.inc = inc; e.wr = wr; e.alu = alu; e.start = start;
        e.done = dn; e.err = er; e.sat = st; e.tmo = tmo;
        return e;
    endfunction

    task automatic do_cmd(input exp_t e, input logic [1:0] op, input logic [CNT_W-1:0] cnt, input int alu_lat);
        exp_t        want;
        int unsigned b_inc, b_wr, b_alu, b_start, b_done, b_err, b_sat, b_ovl;
        int          wait_n = 0;
        int          since  = -1;
        bit          fin    = 1'b0;
        sb.push_back(e);
        @(negedge clock);
        b_inc = n_inc; b_wr = n_wr; b_alu = n_alu; b_start = n_start;
        b_done = n_done; b_err = n_err; b_sat = n_sat; b_ovl = n_overlap;
        cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt;
        while (!cmd_ready && wait_n < 50) begin
            @(negedge clock);
            wait_n++;
        end
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_count = CNT_W'($urandom);
        wait_n = 0;
        while (!fin && wait_n < 400) begin
            if (alu_start) since = 0;
            else if (since >= 0) since++;
            alu_done = (alu_lat > 0) && (since == alu_lat);
            #1;
            if (done || err) begin
                fin = 1'b1;
            end else begin
                @(negedge clock);
                wait_n++;
            end
        end
        @(posedge clock);
        #1;
        alu_done = 1'b0;
        want = sb.pop_front();
        check({want.tag, " completes"}, 32'(fin), 32'd1);
        check({want.tag, " acc"}, 32'(acc_q), 32'(want.acc));
        check({want.tag, " inc strobes"}, n_inc - b_inc, want.inc);
        check({want.tag, " write strobes"}, n_wr - b_wr, want.wr);
        check({want.tag, " alu_to_ac strobes"}, n_alu - b_alu, want.alu);
        check({want.tag, " alu_start pulses"}, n_start - b_start, want.start);
        check({want.tag, " done pulses"}, n_done - b_done, want.done);
        check({want.tag, " err pulses"}, n_err - b_err, want.err);
        check({want.tag, " sat pulses"}, n_sat - b_sat, want.sat);
        check({want.tag, " alu latency"}, since, want.tmo);
        check({want.tag, " strobe overlap"}, n_overlap - b_ovl, 0);
        check({want.tag, " ready after"}, 32'(cmd_ready), 32'd1);
    endtask

    logic [1:0]  ops [4];
    int unsigned b_inc0, b_done0, b_acc0, b_wr0, b_alu0, b_start0;
    int          acc_i;
    bit          prev_start, rdy;

    initial begin
        #1;
        check("reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset strobes", 32'({ac_write_en, ac_alu_to_ac, ac_inc_en, alu_start}), 32'd0);
        check("reset pulses", 32'({done, err, sat}), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        datain = 16'h1234;
        do_cmd(mk("LOAD", 16'h1234, 0, 1, 0, 0, 1, 0, 0, -1), OP_LOAD, '0, 0);
        alu_out = 16'h00FF;
        do_cmd(mk("ALU", 16'h00FF, 0, 0, 1, 1, 1, 0, 0, 3), OP_ALU, '0, 3);
        alu_out = 16'hABCD;
        do_cmd(mk("ALU timeout", 16'h00FF, 0, 0, 0, 1, 0, 1, 0, ALU_TIMEOUT), OP_ALU, '0, 0);
        do_cmd(mk("NOP", 16'h00FF, 0, 0, 0, 0, 1, 0, 0, -1), OP_NOP, 8'd7, 0);
        datain = 16'h0000;
        do_cmd(mk("LOAD 0", 16'h0000, 0, 1, 0, 0, 1, 0, 0, -1), OP_LOAD, '0, 0);
        do_cmd(mk("INC 0", 16'h0000, 0, 0, 0, 0, 1, 0, 0, -1), OP_INC, 8'd0, 0);
        do_cmd(mk("INC 1", 16'h0001, 1, 0, 0, 0, 1, 0, 0, -1), OP_INC, 8'd1, 0);
        do_cmd(mk("LOAD 0b", 16'h0000, 0, 1, 0, 0, 1, 0, 0, -1), OP_LOAD, '0, 0);
        do_cmd(mk("INC 255", 16'h00FF, 255, 0, 0, 0, 1, 0, 0, -1), OP_INC, 8'd255, 0);
        datain = 16'hFFFD;
        do_cmd(mk("LOAD FFFD", 16'hFFFD, 0, 1, 0, 0, 1, 0, 0, -1), OP_LOAD, '0, 0);
`ifdef AC_CTRL_SAT_EN
        do_cmd(mk("INC sat", 16'hFFFF, 2, 0, 0, 0, 1, 0, 1, -1), OP_INC, 8'd10, 0);
`else
        do_cmd(mk("INC wrap", 16'h0007, 10, 0, 0, 0, 1, 0, 0, -1), OP_INC, 8'd10, 0);
`endif

        // Reset asserted after two strobes of a five-count INC.
        datain = 16'h0000;
        do_cmd(mk("LOAD 0c", 16'h0000, 0, 1, 0, 0, 1, 0, 0, -1), OP_LOAD, '0, 0);
        @(negedge clock);
        b_inc0 = n_inc;
        cmd_valid = 1'b1; cmd_op = OP_INC; cmd_count = 8'd5;
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midreset strobes", 32'({ac_write_en, ac_alu_to_ac, ac_inc_en, alu_start}), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset cmd_ready", 32'(cmd_ready), 32'd1);
        check("midreset pulses", 32'({done, err, sat}), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (8) @(negedge clock);
        check("midreset inc count", n_inc - b_inc0, 2);
        check("midreset acc", 32'(acc_q), 32'h2);
        check("midreset ready after", 32'(cmd_ready), 32'd1);

        // Back-to-back commands with cmd_valid held high.
        ops[0] = OP_LOAD; ops[1] = OP_NOP; ops[2] = OP_ALU; ops[3] = OP_INC;
        datain = 16'h0042; alu_out = 16'h0100;
        @(negedge clock);
        b_inc0 = n_inc; b_done0 = n_done; b_acc0 = n_acc; b_wr0 = n_wr; b_alu0 = n_alu; b_start0 = n_start;
        acc_i = 0; prev_start = 1'b0; b_inc0 = n_inc;
        cmd_count = 8'd3;
        for (int c = 0; c < 40; c++) begin
            alu_done   = prev_start;
            prev_start = alu_start;
            if (acc_i < 4) begin
                cmd_valid = 1'b1;
                cmd_op    = ops[acc_i];
            end else begin
                cmd_valid = 1'b0;
            end
            rdy = cmd_valid && cmd_ready;
            @(posedge clock);
            if (rdy) acc_i++;
            @(negedge clock);
        end
        alu_done = 1'b0;
        check("b2b accepted", acc_i, 4);
        check("b2b accept edges", n_acc - b_acc0, 4);
        check("b2b done count", n_done - b_done0, 4);
        check("b2b writes", n_wr - b_wr0, 1);
        check("b2b alu writes", n_alu - b_alu0, 1);
        check("b2b alu starts", n_start - b_start0, 1);
        check("b2b incs", n_inc - b_inc0, 3);
        check("b2b acc", 32'(acc_q), 32'h0103);
        check("total overlap", n_overlap, 0);
        check("scoreboard drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
